// File: rtl/traceback_unit_if.sv
// rtl/traceback_unit_if.sv - traceback request, survivor-memory read and decoded-bit stream bundle
// master drives requests, survivor bits and out_ready; slave is the traceback unit.
interface traceback_unit_if #(
  parameter int M = 4,
  parameter int D = 10
);
  localparam int TW = $clog2(D);

  logic          start;
  logic [M-1:0]  start_state;
  logic [TW-1:0] start_time;
  logic          busy;
  logic [M-1:0]  rd_state;
  logic [TW-1:0] rd_time;
  logic          surv_bit;
  logic          out_valid;
  logic          out_bit;
  logic          out_ready;
  logic          done;

  modport master (
    output start, start_state, start_time, surv_bit, out_ready,
    input  busy, rd_state, rd_time, out_valid, out_bit, done
  );

  modport slave (
    input  start, start_state, start_time, surv_bit, out_ready,
    output busy, rd_state, rd_time, out_valid, out_bit, done
  );
endinterface

// File: rtl/traceback_unit.sv
// rtl/traceback_unit.sv - Viterbi survivor-memory traceback with buffered, flow-controlled bit output
// Optional abort input enabled by defining TRACEBACK_ABORT_EN.
module traceback_unit #(
  parameter int K      = 5,
  parameter int M      = K - 1,
  parameter int S      = 1 << M,
  parameter int D      = 10,
  parameter int TB_LEN = 6
) (
  input logic clk,
  input logic rst,
`ifdef TRACEBACK_ABORT_EN
  input logic abort,
`endif
  traceback_unit_if.slave tb_if
);
  localparam int OUT_LEN = D - TB_LEN;
  localparam int TW      = $clog2(D);
  localparam int RSW     = $clog2(S);
  localparam int IW      = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

  typedef enum logic [1:0] {IDLE, TRACE, DRAIN} state_e;

  state_e               state_q;
  logic [M-1:0]         cur_state_q;
  logic [M-1:0]         cur_state_d;
  logic [TW-1:0]        cur_time_q;
  logic [TW-1:0]        cur_time_d;
  logic [TW-1:0]        step_q;
  logic [IW-1:0]        idx_q;
  logic [OUT_LEN-1:0]   buf_q;
  logic                 out_valid_q;
  logic                 out_bit_q;
  logic                 done_q;
  logic                 abort_hit;

`ifdef TRACEBACK_ABORT_EN
  assign abort_hit = abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Walk one step back in time: the survivor bit becomes the new LSB of the predecessor state.
  assign cur_state_d = {cur_state_q[M-2:0], tb_if.surv_bit};
  assign cur_time_d  = (cur_time_q == '0) ? TW'(D - 1) : cur_time_q - TW'(1);

  assign tb_if.rd_state  = RSW'(cur_state_q);
  assign tb_if.rd_time   = cur_time_q;
  assign tb_if.busy      = (state_q != IDLE);
  assign tb_if.out_valid = out_valid_q;
  assign tb_if.out_bit   = out_bit_q;
  assign tb_if.done      = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_state_q <= '0;
      cur_time_q  <= '0;
      step_q      <= '0;
      idx_q       <= '0;
      buf_q       <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort_hit && state_q != IDLE) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tb_if.start) begin
            cur_state_q <= tb_if.start_state;
            cur_time_q  <= tb_if.start_time;
            step_q      <= '0;
            state_q     <= TRACE;
          end
        end
        TRACE: begin
          cur_state_q <= cur_state_d;
          cur_time_q  <= cur_time_d;
          step_q      <= step_q + TW'(1);
          for (int i = 0; i < OUT_LEN; i++) begin
            if (step_q == TW'(TB_LEN + i)) buf_q[i] <= cur_state_q[M-1];
          end
          // The last step writes the oldest entry, so it is forwarded straight to the output.
          if (step_q == TW'(D - 1)) begin
            state_q     <= DRAIN;
            idx_q       <= IW'(OUT_LEN - 1);
            out_valid_q <= 1'b1;
            out_bit_q   <= cur_state_q[M-1];
          end
        end
        DRAIN: begin
          if (out_valid_q && tb_if.out_ready) begin
            if (idx_q == '0) begin
              state_q     <= IDLE;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              idx_q <= idx_q - IW'(1);
              for (int i = 0; i < OUT_LEN - 1; i++) begin
                if (idx_q == IW'(i + 1)) out_bit_q <= buf_q[i];
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/traceback_unit.md
TRACEBACK_UNIT -- requirements
Module: traceback_unit

Interface
REQ-001 SHALL have parameter K, default 5, constraint length.
REQ-002 SHALL have parameter M, default K-1, state bits.
REQ-003 SHALL have parameter S, default 1<<M, state count.
REQ-004 SHALL have parameter D, default 10, survivor memory depth in rows.
REQ-005 SHALL have parameter TB_LEN, default 6, merge steps with no output (1 <= TB_LEN < D).
REQ-006 SHALL have clk, input, 1, clock.
REQ-007 SHALL have rst, input, 1; reset rst, synchronous, active-high; clock clk.
REQ-008 SHALL have start, input, 1, traceback request pulse.
REQ-009 SHALL have start_state, input, M, traceback starting (best-metric) state.
REQ-010 SHALL have start_time, input, $clog2(D), newest written row index.
REQ-011 SHALL have busy, output, 1, high in any state other than IDLE.
REQ-012 SHALL have rd_state, output, $clog2(S), survivor memory state select.
REQ-013 SHALL have rd_time, output, $clog2(D), survivor memory row select.
REQ-014 SHALL have surv_bit, input, 1, combinational survivor bit for (rd_time, rd_state), valid in the same cycle.
REQ-015 SHALL have out_valid, output, 1; out_bit, output, 1; out_ready, input, 1; decoded bit stream.
REQ-016 SHALL have done, output, 1, one-cycle pulse when the last bit is accepted.

Function
REQ-017 SHALL define OUT_LEN = D - TB_LEN, with decoded bits held in an internal OUT_LEN-entry buffer.
REQ-018 SHALL implement FSM states IDLE, TRACE, DRAIN.
REQ-019 SHALL, in IDLE with start=1, register cur_state=start_state, cur_time=start_time, step=0, and enter TRACE.
REQ-020 SHALL ignore start outside IDLE.
REQ-021 SHALL drive rd_state=cur_state and rd_time=cur_time directly from registers, with one traceback step per TRACE cycle.
REQ-022 SHALL, on each TRACE step, set next cur_state = {cur_state[M-2:0], surv_bit}.
REQ-023 SHALL, on each TRACE step with step >= TB_LEN, write cur_state[M-1] to buffer[step-TB_LEN].
REQ-024 SHALL decrement cur_time each step, wrapping 0 -> D-1.
REQ-025 SHALL enter DRAIN after step D-1, so TRACE lasts exactly D cycles.
REQ-026 SHALL, in DRAIN, present buffer entries oldest first, index OUT_LEN-1 down to 0, with out_valid=1.
REQ-027 SHALL advance the DRAIN entry only on out_valid & out_ready.
REQ-028 SHALL hold out_bit stable while out_valid=1 and out_ready=0.
REQ-029 SHALL, on acceptance of the index-0 entry, pulse done for 1 cycle, return to IDLE and deassert out_valid.
REQ-030 SHALL accept a new start in the cycle after done.
REQ-031 SHALL keep out_valid=0 in IDLE and TRACE.
REQ-032 SHALL give minimum start-to-done latency of 1+D+OUT_LEN-1 cycles with out_ready held high.

Reset
REQ-033 SHALL, on rst, set FSM=IDLE, busy=0, out_valid=0, out_bit=0, done=0, rd_state=0, rd_time=0, step=0 and buffer=0.
REQ-034 SHALL give rst priority over all other inputs, aborting any traceback or drain in progress without a done pulse.

Configuration
REQ-035 SHALL, when macro TRACEBACK_ABORT_EN is defined, add input abort (1 bit), which in TRACE or DRAIN returns the FSM to IDLE next cycle with out_valid=0 and no done; abort in IDLE SHALL have no effect.
REQ-036 SHALL, without TRACEBACK_ABORT_EN, omit the abort port, with all other behaviour identical.

Verification (K=5, D=10, TB_LEN=6, OUT_LEN=4)
REQ-037 SHALL cover: memory all 0, start_state=0, start_time=9, out_ready=1 -> out_bit 0,0,0,0; done 14 cycles after start.
REQ-038 SHALL cover: memory all 1, start_state=0 -> states 0,1,3,7,15... ; out_bit 1,1,1,1.
REQ-039 SHALL cover: start_time=2 -> rd_time sequence 2,1,0,9,8,7,6,5,4,3.
REQ-040 SHALL cover: out_ready low 5 cycles during DRAIN -> out_bit stable, no bit lost or duplicated; start while busy ignored.
REQ-041 SHALL cover: rst at TRACE step 4 -> next cycle busy=0, out_valid=0, no done; new start decodes correctly.
REQ-042 SHALL cover: with TRACEBACK_ABORT_EN, abort during DRAIN after 2 bits -> IDLE, out_valid=0, done never pulses.
